// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the ADC sample packer.
// The TRAILER state exists only when ADC_PACKER_CHECKSUM_EN is defined.
package adc_pkg;

    localparam int WORD_W   = 32;
    localparam int SAMPLE_W = 16;

    localparam logic [15:0] HEADER_MARK  = 16'hA5A5;
    localparam logic [15:0] TRAILER_MARK = 16'h5A5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PACK_LO,
`ifdef ADC_PACKER_CHECKSUM_EN
        ST_PACK_HI,
        ST_TRAILER
`else
        ST_PACK_HI
`endif
    } state_t;

endpackage

// File: rtl/adc_word_fifo.sv
// First-word-fall-through word FIFO with occupancy output.
// A write into a full FIFO is accepted only if a read happens in the same cycle.
module adc_word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             drop,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic             full;
    logic             rd_fire;
    logic             wr_fire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr - rd_ptr;
    assign valid   = (level != '0);
    assign full    = (level == LW'(DEPTH));
    assign rd_fire = rd_en & valid;
    assign wr_fire = wr_en & (~full | rd_fire);
    assign drop    = wr_en & full & ~rd_fire;
    assign rd_data = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/adc_sample_packer.sv
// Packs pairs of 16-bit ADC samples into 32-bit words framed by a header
// (and a checksum trailer when ADC_PACKER_CHECKSUM_EN is defined).
module adc_sample_packer
    import adc_pkg::*;
#(
    parameter int FRAME_SAMPLES = 256,
    parameter int FIFO_DEPTH    = 16,
    localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk_adc,
    input  logic                rst,
    input  logic                enable_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                sample_valid_i,
    output logic [WORD_W-1:0]   word_o,
    output logic                word_valid_o,
    input  logic                word_ready_i,
    output logic                frame_busy_o,
    output logic                overflow_o,
    input  logic                overflow_clr_i,
    output logic [LW-1:0]       fifo_level_o
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_SAMPLES - 1);

    state_t              state;
    state_t              next_state;
    logic [15:0]         frame_cnt;
    logic [15:0]         sample_cnt;
    logic [SAMPLE_W-1:0] low_half;
    logic                fifo_wr;
    logic [WORD_W-1:0]   fifo_data;
    logic                fifo_drop;
    logic                last_sample;

`ifdef ADC_PACKER_CHECKSUM_EN
    logic [SAMPLE_W-1:0] checksum;
`endif

    assign last_sample  = (sample_cnt == LAST_IDX);
    assign frame_busy_o = (state != ST_IDLE);

    always_comb begin
        next_state = state;
        fifo_wr    = 1'b0;
        fifo_data  = '0;
        case (state)
            ST_IDLE: begin
                if (enable_i) next_state = ST_HEADER;
            end
            ST_HEADER: begin
                fifo_wr    = 1'b1;
                fifo_data  = {HEADER_MARK, frame_cnt};
                next_state = ST_PACK_LO;
            end
            ST_PACK_LO: begin
                if (sample_valid_i) next_state = ST_PACK_HI;
            end
            ST_PACK_HI: begin
                if (sample_valid_i) begin
                    fifo_wr   = 1'b1;
                    fifo_data = {sample_i, low_half};
                    if (last_sample) begin
`ifdef ADC_PACKER_CHECKSUM_EN
                        next_state = ST_TRAILER;
`else
                        next_state = ST_IDLE;
`endif
                    end else begin
                        next_state = ST_PACK_LO;
                    end
                end
            end
`ifdef ADC_PACKER_CHECKSUM_EN
            ST_TRAILER: begin
                fifo_wr    = 1'b1;
                fifo_data  = {TRAILER_MARK, checksum};
                next_state = ST_IDLE;
            end
`endif
            default: next_state = ST_IDLE;
        endcase
    end

    // enable_i is only looked at in IDLE, so dropping it mid-frame has no effect.
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            frame_cnt  <= '0;
            sample_cnt <= '0;
            low_half   <= '0;
        end else begin
            state <= next_state;
            if (state == ST_HEADER) frame_cnt <= frame_cnt + 16'd1;
            if (state == ST_PACK_LO && sample_valid_i) begin
                low_half   <= sample_i;
                sample_cnt <= sample_cnt + 16'd1;
            end
            if (state == ST_PACK_HI && sample_valid_i)
                sample_cnt <= last_sample ? 16'd0 : sample_cnt + 16'd1;
        end
    end

`ifdef ADC_PACKER_CHECKSUM_EN
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (state == ST_HEADER) begin
            checksum <= '0;
        end else if ((state == ST_PACK_LO || state == ST_PACK_HI) && sample_valid_i) begin
            checksum <= checksum ^ sample_i;
        end
    end
`endif

    // A fresh drop outranks a clear request in the same cycle.
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (fifo_drop) begin
            overflow_o <= 1'b1;
        end else if (overflow_clr_i) begin
            overflow_o <= 1'b0;
        end
    end

    adc_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk_adc),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (fifo_data),
        .rd_en   (word_ready_i),
        .rd_data (word_o),
        .valid   (word_valid_o),
        .drop    (fifo_drop),
        .level   (fifo_level_o)
    );

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed bench for adc_sample_packer with 4-sample frames and a 4-word FIFO.
// Expected trailer words apply when ADC_PACKER_CHECKSUM_EN is defined.
module tb_adc_sample_packer;

`ifdef ADC_PACKER_CHECKSUM_EN
    localparam int WPF = 4;
`else
    localparam int WPF = 3;
`endif

    logic        clk_adc = 1'b0;
    logic        rst;
    logic        enable_i;
    logic [15:0] sample_i;
    logic        sample_valid_i;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i;
    logic        frame_busy_o;
    logic        overflow_o;
    logic        overflow_clr_i;
    logic [2:0]  fifo_level_o;

    int passed = 0;
    int total  = 0;

    adc_sample_packer #(
        .FRAME_SAMPLES (4),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk_adc        (clk_adc),
        .rst            (rst),
        .enable_i       (enable_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .word_o         (word_o),
        .word_valid_o   (word_valid_o),
        .word_ready_i   (word_ready_i),
        .frame_busy_o   (frame_busy_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i),
        .fifo_level_o   (fifo_level_o)
    );

    always #5 clk_adc = ~clk_adc;

    task automatic applyStimulus(input logic en, input logic vld, input logic [15:0] smp,
                                 input logic rdy, input logic clr);
        enable_i       = en;
        sample_valid_i = vld;
        sample_i       = smp;
        word_ready_i   = rdy;
        overflow_clr_i = clr;
        @(negedge clk_adc);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Header cycle optionally carries a stray sample that must be ignored.
    task automatic runFrame(input logic [15:0] s0, input logic hdr_junk);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, hdr_junk, 16'h7777, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b1, s0 + 16'(i), 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic popWord(input string tag, input logic [31:0] expected);
        checkOutput({tag, "_valid"}, {31'b0, word_valid_o}, 32'd1);
        checkOutput(tag, word_o, expected);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic popFrame(input logic [15:0] fc, input logic [15:0] s0);
        popWord("hdr", {16'hA5A5, fc});
        popWord("w0", {s0 + 16'd1, s0});
        popWord("w1", {s0 + 16'd3, s0 + 16'd2});
`ifdef ADC_PACKER_CHECKSUM_EN
        popWord("trl", {16'h5A5A, s0 ^ (s0 + 16'd1) ^ (s0 + 16'd2) ^ (s0 + 16'd3)});
`endif
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk_adc);
        rst = 1'b0;
        @(negedge clk_adc);
    endtask

    initial begin
        rst            = 1'b1;
        enable_i       = 1'b0;
        sample_i       = 16'h0;
        sample_valid_i = 1'b0;
        word_ready_i   = 1'b0;
        overflow_clr_i = 1'b0;
        repeat (2) @(negedge clk_adc);
        checkOutput("rst_valid", {31'b0, word_valid_o}, 32'd0);
        checkOutput("rst_word", word_o, 32'd0);
        checkOutput("rst_busy", {31'b0, frame_busy_o}, 32'd0);
        checkOutput("rst_ovf", {31'b0, overflow_o}, 32'd0);
        checkOutput("rst_level", {29'b0, fifo_level_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk_adc);

        // Frame 0 with a stray sample while idle
        applyStimulus(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
        checkOutput("idle_level", {29'b0, fifo_level_o}, 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("hdr_busy", {31'b0, frame_busy_o}, 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("fwft_valid", {31'b0, word_valid_o}, 32'd1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b1, 16'(i + 1), 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("f0_level", {29'b0, fifo_level_o}, WPF);
        checkOutput("f0_busy", {31'b0, frame_busy_o}, 32'd0);
        popFrame(16'h0000, 16'h0001);
        checkOutput("f0_empty", {29'b0, fifo_level_o}, 32'd0);

        // Frame 1 with a stray sample during HEADER
        runFrame(16'h0005, 1'b1);
        popFrame(16'h0001, 16'h0005);

        // frame_cnt wrap
        force dut.frame_cnt = 16'hFFFF;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        release dut.frame_cnt;
        runFrame(16'h0060, 1'b0);
        popFrame(16'hFFFF, 16'h0060);
        runFrame(16'h0070, 1'b0);
        popFrame(16'h0000, 16'h0070);

        // Overflow with the consumer stalled
        doReset();
        runFrame(16'h0010, 1'b0);
        runFrame(16'h0020, 1'b0);
        checkOutput("ovf_level", {29'b0, fifo_level_o}, 32'd4);
        checkOutput("ovf_flag", {31'b0, overflow_o}, 32'd1);
        checkOutput("ovf_head", word_o, 32'hA5A50000);
        repeat (2) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        checkOutput("ovf_hold", word_o, 32'hA5A50000);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("clr_alone", {31'b0, overflow_o}, 32'd0);

        // Clear coinciding with a dropped header, then full write+read
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("clr_vs_drop", {31'b0, overflow_o}, 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("clr_again", {31'b0, overflow_o}, 32'd0);
        applyStimulus(1'b0, 1'b1, 16'h0031, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0032, 1'b1, 1'b0);
        checkOutput("wr_rd_ovf", {31'b0, overflow_o}, 32'd0);
        checkOutput("wr_rd_level", {29'b0, fifo_level_o}, 32'd4);
        checkOutput("wr_rd_head", word_o, 32'h00110010);
        applyStimulus(1'b0, 1'b1, 16'h0033, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0034, 1'b0, 1'b0);
        checkOutput("drop_again", {31'b0, overflow_o}, 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        popWord("d0", 32'h00110010);
        popWord("d1", 32'h00130012);
`ifdef ADC_PACKER_CHECKSUM_EN
        popWord("d2", 32'h5A5A0000);
`else
        popWord("d2", 32'hA5A50001);
`endif
        popWord("d3", 32'h00320031);
        checkOutput("drain_level", {29'b0, fifo_level_o}, 32'd0);

        // Reset in the middle of a frame
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 16'h0041 + 16'(i), 1'b0, 1'b0);
        sample_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", {31'b0, frame_busy_o}, 32'd0);
        checkOutput("mid_rst_valid", {31'b0, word_valid_o}, 32'd0);
        checkOutput("mid_rst_word", word_o, 32'd0);
        checkOutput("mid_rst_level", {29'b0, fifo_level_o}, 32'd0);
        checkOutput("mid_rst_ovf", {31'b0, overflow_o}, 32'd0);
        @(negedge clk_adc);
        rst = 1'b0;
        @(negedge clk_adc);
        runFrame(16'h0050, 1'b0);
        checkOutput("post_rst_level", {29'b0, fifo_level_o}, WPF);
        popWord("post_rst_hdr", 32'hA5A50000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
